// File: rtl/spi_miso_transmitter.sv
// -----------------------------------------------------------------------------
// spi_miso_transmitter
//
// Slave-side SPI mode-0 transmit path. Bytes queued from the i_Clk domain
// through a valid/ready handshake are held in a DEPTH-entry circular FIFO.
// They are shifted out MSB first on MISO, clocked by the synchronised SCK.
// SCK and CS_n are oversampled by i_Clk. Each goes through a 2-flop
// synchroniser followed by one edge-detect register.
//
// Parameters:
//   DEPTH      FIFO depth in bytes (power of two, 2..64)
//   IDLE_BYTE  byte sent when the FIFO is empty at a byte boundary
//
// Ports:
//   i_Clk          system clock, the only clock
//   i_Rst          synchronous active-high reset
//   i_TX_DV        write strobe, accepted when i_TX_DV && o_TX_Ready
//   i_TX_Byte      byte to queue
//   o_TX_Ready     FIFO not full (registered)
//   o_TX_Sent      one-cycle pulse when a byte finished all 8 bits
//   i_SPI_Clk      SCK, asynchronous
//   i_SPI_CS_n     chip select, active-low, asynchronous
//   o_SPI_MISO     serial data out
//   o_SPI_MISO_En  pad output enable, high while a frame is being served
//   o_FIFO_Level   current FIFO occupancy (registered)
//   o_Underrun_Cnt saturating count of LOADs that found the FIFO empty
//                  (present only when SPI_TX_UNDERRUN_CNT_EN is defined)
//
// Build option: define SPI_TX_UNDERRUN_CNT_EN to add o_Underrun_Cnt.
//
// FSM states:
//   state | meaning
//   IDLE  | no frame; MISO and its enable held low
//   LOAD  | one cycle: fetch FIFO head (or IDLE_BYTE), present its MSB
//   SHIFT | count SCK rises, present the next bit on each SCK fall
// -----------------------------------------------------------------------------
module spi_miso_transmitter #(
    parameter int          DEPTH     = 8,
    parameter logic [7:0]  IDLE_BYTE = 8'h00
) (
    input  logic                       i_Clk,
    input  logic                       i_Rst,
    input  logic                       i_TX_DV,
    input  logic [7:0]                 i_TX_Byte,
    output logic                       o_TX_Ready,
    output logic                       o_TX_Sent,
    input  logic                       i_SPI_Clk,
    input  logic                       i_SPI_CS_n,
    output logic                       o_SPI_MISO,
    output logic                       o_SPI_MISO_En,
`ifdef SPI_TX_UNDERRUN_CNT_EN
    output logic [7:0]                 o_Underrun_Cnt,
`endif
    output logic [$clog2(DEPTH):0]     o_FIFO_Level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Synchronisers and edge detection
    // ------------------------------------------------------------------
    logic r_sck_s1, r_sck_s2, r_sck_s3;
    logic r_cs_s1,  r_cs_s2,  r_cs_s3;
    logic w_sck_rise, w_sck_fall;
    logic w_cs_rise,  w_cs_fall;

    // The CS_n chain resets low. If CS_n is still asserted when reset is
    // released, no falling edge is seen. The frame can only restart after
    // CS_n has gone high and then low again.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_sck_s1 <= 1'b0;
            r_sck_s2 <= 1'b0;
            r_sck_s3 <= 1'b0;
            r_cs_s1  <= 1'b0;
            r_cs_s2  <= 1'b0;
            r_cs_s3  <= 1'b0;
        end else begin
            r_sck_s1 <= i_SPI_Clk;
            r_sck_s2 <= r_sck_s1;
            r_sck_s3 <= r_sck_s2;
            r_cs_s1  <= i_SPI_CS_n;
            r_cs_s2  <= r_cs_s1;
            r_cs_s3  <= r_cs_s2;
        end
    end

    assign w_sck_rise =  r_sck_s2 & ~r_sck_s3;
    assign w_sck_fall = ~r_sck_s2 &  r_sck_s3;
    assign w_cs_rise  =  r_cs_s2  & ~r_cs_s3;
    assign w_cs_fall  = ~r_cs_s2  &  r_cs_s3;

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [7:0]    r_mem [DEPTH];
    logic [LW-1:0] r_wr_ptr, r_rd_ptr;
    logic [LW-1:0] w_wr_ptr_nxt, w_rd_ptr_nxt;
    logic [LW-1:0] r_level;
    logic          r_ready;
    logic          w_push, w_pop, w_empty, w_full_nxt;
    logic          w_load_fire, w_underrun;
    logic [7:0]    w_head, w_load_byte;

    state_t        r_state;

    // r_ready is registered. A slot freed by a pop is therefore offered
    // to the writer only on the following cycle.
    assign w_push       = i_TX_DV & r_ready;
    assign w_empty      = (r_wr_ptr == r_rd_ptr);
    assign w_load_fire  = (r_state == S_LOAD) & ~w_cs_rise;
    assign w_pop        = w_load_fire & ~w_empty;
    assign w_underrun   = w_load_fire &  w_empty;

    assign w_wr_ptr_nxt = r_wr_ptr + {{(LW-1){1'b0}}, w_push};
    assign w_rd_ptr_nxt = r_rd_ptr + {{(LW-1){1'b0}}, w_pop};
    assign w_full_nxt   = (w_wr_ptr_nxt[AW] != w_rd_ptr_nxt[AW]) &&
                          (w_wr_ptr_nxt[AW-1:0] == w_rd_ptr_nxt[AW-1:0]);

    assign w_head       = r_mem[r_rd_ptr[AW-1:0]];
    assign w_load_byte  = w_empty ? IDLE_BYTE : w_head;

    always_ff @(posedge i_Clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_TX_Byte;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_ready  <= 1'b1;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_level  <= w_wr_ptr_nxt - w_rd_ptr_nxt;
            r_ready  <= ~w_full_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------
    // r_shift holds the bits still to be sent after the one on MISO.
    logic [6:0] r_shift;
    logic [3:0] r_bit_cnt;
    logic       r_miso;
    logic       r_miso_en;
    logic       r_sent;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_miso    <= 1'b0;
            r_miso_en <= 1'b0;
            r_sent    <= 1'b0;
        end else begin
            r_sent <= 1'b0;
            if (w_cs_rise) begin
                // Any partial byte is abandoned. No sent pulse is issued for it.
                r_state   <= S_IDLE;
                r_bit_cnt <= '0;
                r_miso    <= 1'b0;
                r_miso_en <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_miso    <= 1'b0;
                        r_miso_en <= 1'b0;
                        if (w_cs_fall) begin
                            r_state   <= S_LOAD;
                            r_miso_en <= 1'b1;
                        end
                    end
                    S_LOAD: begin
                        r_shift   <= w_load_byte[6:0];
                        r_miso    <= w_load_byte[7];
                        r_miso_en <= 1'b1;
                        r_bit_cnt <= '0;
                        r_state   <= S_SHIFT;
                    end
                    S_SHIFT: begin
                        if (w_sck_rise && (r_bit_cnt < 4'd8)) begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            if (r_bit_cnt == 4'd7) begin
                                r_sent <= 1'b1;
                            end
                        end else if (w_sck_fall) begin
                            if (r_bit_cnt == 4'd8) begin
                                // Byte finished: fetch the next one in the same frame.
                                r_state <= S_LOAD;
                            end else begin
                                r_miso  <= r_shift[6];
                                r_shift <= {r_shift[5:0], 1'b0};
                            end
                        end
                    end
                    default: begin
                        r_state   <= S_IDLE;
                        r_miso    <= 1'b0;
                        r_miso_en <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef SPI_TX_UNDERRUN_CNT_EN
    logic [7:0] r_underrun_cnt;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_underrun_cnt <= '0;
        end else if (w_underrun && (r_underrun_cnt != 8'hFF)) begin
            r_underrun_cnt <= r_underrun_cnt + 8'd1;
        end
    end

    assign o_Underrun_Cnt = r_underrun_cnt;
`else
    // Underruns still send IDLE_BYTE through w_load_byte. Only the
    // counter is left out of this build.
    logic w_underrun_unused;
    assign w_underrun_unused = w_underrun;
`endif

    assign o_TX_Ready    = r_ready;
    assign o_TX_Sent     = r_sent;
    assign o_SPI_MISO    = r_miso;
    assign o_SPI_MISO_En = r_miso_en;
    assign o_FIFO_Level  = r_level;

endmodule

// File: doc/spi_miso_transmitter.md
# spi_miso_transmitter

Slave-side SPI transmit path that returns bytes from the Raytracing_Controller to the external master over MISO, complementing the existing receive path on MOSI. A DEPTH-entry byte FIFO, written in the i_Clk domain with a valid/ready handshake, feeds an SPI mode-0 (CPOL=0, CPHA=0) shifter. SCK and CS_n are oversampled and synchronised into i_Clk. The block sits beside SPI_Slave in Top and shares its SPI pins and system clock.

## Interface
- DEPTH, 8: FIFO depth in bytes; power of two, 2..64.
- IDLE_BYTE, 8'h00: byte shifted out when the FIFO is empty at a byte boundary.
- i_Clk  in  1  system clock (100 MHz); the only clock.
- i_Rst  in  1  reset, synchronous, active-high.
- i_TX_DV  in  1  write strobe; the byte is accepted when i_TX_DV && o_TX_Ready.
- i_TX_Byte  in  8  byte to queue.
- o_TX_Ready  out  1  FIFO not full.
- o_TX_Sent  out  1  one-cycle pulse: a byte completed all 8 bits on the wire.
- i_SPI_Clk  in  1  SCK, asynchronous to i_Clk.
- i_SPI_CS_n  in  1  chip select, active-low, asynchronous.
- o_SPI_MISO  out  1  serial data, MSB first.
- o_SPI_MISO_En  out  1  high while the synchronised CS_n is low; drives the pad tristate.
- o_FIFO_Level  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- Synchronisers: 2-flop for SCK and CS_n, plus a third register for edge detection. All SPI events below refer to synchronised edges.
- FIFO: circular buffer with pointers of $clog2(DEPTH)+1 bits; the MSB distinguishes full from empty.
  - Push and pop in the same cycle: both take effect and the level is unchanged.
  - Push while full: ignored, because o_TX_Ready is low. A push on the cycle a pop frees space is still refused; o_TX_Ready rises on the next cycle.
- FSM states: IDLE, LOAD, SHIFT.
  - IDLE: MISO = 0, En = 0. A CS_n falling edge moves to LOAD.
  - LOAD, one cycle: shift register <= FIFO head (popped) if not empty, else IDLE_BYTE. bit_cnt <= 0. MISO <= bit 7. Go to SHIFT.
  - SHIFT:
    - On each SCK rising edge: bit_cnt++.
    - On the rising edge that brings bit_cnt to 8: pulse o_TX_Sent.
    - On each SCK falling edge with bit_cnt < 8: shift left and present the next bit.
    - On the falling edge with bit_cnt == 8: go to LOAD, so the next byte streams back-to-back within the same CS frame.
  - Any state: a CS_n rising edge returns to IDLE.
    - A partially shifted byte is discarded, not re-queued, and o_TX_Sent is not pulsed for it.
    - A byte popped in LOAD but never clocked is also lost.
- An underrun (FIFO empty at LOAD) sends IDLE_BYTE. It is not an error for the FIFO.
- Reset mid-frame: return to IDLE and empty the FIFO. The frame resumes only after CS_n goes high then low again.

## Timing
- Reset values:
  - o_SPI_MISO = 0, o_SPI_MISO_En = 0, o_TX_Sent = 0.
  - o_TX_Ready = 1, o_FIFO_Level = 0.
  - FSM in IDLE, FIFO pointers 0.
- Write latency: a byte accepted in cycle N is counted in o_FIFO_Level at N+1 and is eligible for LOAD from N+1.
- First bit: MISO is valid 4 i_Clk cycles after the raw CS_n fall (2 sync + 1 edge + 1 LOAD).
- Master constraints:
  - CS_n to first SCK rise ≥ 80 ns.
  - SCK high and SCK low each ≥ 4 i_Clk cycles, i.e. SCK ≤ 12.5 MHz.
- Each bit change lags the raw SCK fall by 3 i_Clk cycles. The following SCK rise therefore still samples stable data under the SCK-low constraint.
- Next-byte MSB is valid 4 cycles after the 8th SCK fall.
- o_TX_Sent occurs 3 cycles after the 8th raw SCK rise.
- o_TX_Ready and o_FIFO_Level are registered and update one cycle after the push or pop.

## Configuration
- SPI_TX_UNDERRUN_CNT_EN:
  - Defined: adds output o_Underrun_Cnt [7:0]. It increments on every LOAD that finds the FIFO empty, saturates at 255, and clears only on i_Rst.
  - Undefined: the port and counter are absent; underrun behaviour on the wire is identical.

## Test plan
- Queue 8'hA5, assert CS_n, then 8 SCK cycles at 5 MHz -> MISO samples 1,0,1,0,0,1,0,1 on rising edges; one o_TX_Sent pulse; level 1->0.
- Queue 8'h3C and 8'hF0, run 16 SCK cycles in one frame -> 0x3C then 0xF0 back-to-back; two o_TX_Sent pulses; o_TX_Ready stays 1.
- Empty FIFO, 8 SCK cycles -> MISO reads 8'h00 (IDLE_BYTE); with SPI_TX_UNDERRUN_CNT_EN, o_Underrun_Cnt = 1.
- Push DEPTH+2 bytes with i_TX_DV held high -> o_TX_Ready falls after DEPTH accepts; o_FIFO_Level = DEPTH; the extra 2 bytes are dropped. Then pop 1 while pushing -> push refused that cycle and accepted the next.
- Raise CS_n after 3 SCK cycles of 8'h81, queue 8'h7E, start a new frame -> no o_TX_Sent for 0x81; the new frame shifts 0x7E.
- Assert i_Rst mid-byte with 3 bytes queued -> next cycle MISO = 0, En = 0, level = 0, o_TX_Ready = 1; the next frame returns IDLE_BYTE.
